frame_align: RTL

//   Receive-side frame aligner; sits directly upstream of the frame position counter.
//   - Hunts a raw byte stream for the 6-byte frame alignment signal (FAS).
//   - Confirms alignment over two consecutive frames, then forwards whole frames only.
//   - Output starts on a frame boundary, so the downstream counter's row/col track true frame position.
//   - Declares loss of alignment after repeated FAS misses and pulses o_resync to restart the counter.
//

---
 rtl/frame_align_pkg.sv | 23 ++
 rtl/frame_align_fas_det.sv | 32 +++
 rtl/frame_align.sv | 128 ++++++++++++
 3 files changed

// File: rtl/frame_align_pkg.sv
// Shared constants and types for the receive-side frame aligner.
package frame_align_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 1041;
  localparam int FRAME_LEN  = ROWS * COLS;
  localparam int FAS_LEN    = 6;
  localparam int MISS_LIMIT = 5;
  localparam int POS_W      = $clog2(FRAME_LEN);
  localparam int MISS_W     = $clog2(MISS_LIMIT + 1);

  // First FAS byte sits in the MSBs.
  localparam logic [8*FAS_LEN-1:0] FAS = 48'hF6F6F6282828;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_e;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/frame_align_fas_det.sv
// FAS detector: keeps the previous FAS_LEN-1 valid bytes and flags a hit when
// they, together with the current byte, form the alignment pattern.
module frame_align_fas_det
  import frame_align_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_hit
);

  localparam int HIST_W = 8 * (FAS_LEN - 1);

  logic [HIST_W-1:0]    hist_q, hist_d;
  logic [8*FAS_LEN-1:0] window;

  always_comb begin
    window = {hist_q, i_data};
    hist_d = i_valid ? window[HIST_W-1:0] : hist_q;
    o_hit  = i_valid && (window == FAS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/frame_align.sv
// Frame aligner: hunts for the FAS, confirms it one frame later, then forwards
// whole frames only, dropping back to hunting after repeated FAS misses.
module frame_align
  import frame_align_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_sof,
  output logic       o_locked,
  output logic       o_resync
);

  localparam pos_t              POS_CHK   = pos_t'(FAS_LEN - 1);
  localparam pos_t              POS_AFTER = pos_t'(FAS_LEN);
  localparam pos_t              POS_LAST  = pos_t'(FRAME_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [MISS_W-1:0] MISS_SAT  = MISS_W'(MISS_LIMIT);

  state_e            state_q, state_d;
  pos_t              pos_q, pos_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              emit_q, emit_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              resync_q, resync_d;

  logic hit;
  logic at_chk;
  logic lose;
  logic emit_set;

  frame_align_fas_det u_fas_det (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_hit   (hit)
  );

  assign at_chk   = (pos_q == POS_CHK);
  assign lose     = i_valid && (state_q == SYNC) && at_chk && !hit && (miss_q >= MISS_LAST);
  // The partial frame in flight at SYNC entry is skipped: emission starts at pos 0.
  assign emit_set = i_valid && (state_q == SYNC) && (pos_q == '0) && !emit_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_valid) begin
      unique case (state_q)
        HUNT:    if (hit) state_d = PRESYNC;
        PRESYNC: if (at_chk) state_d = hit ? SYNC : HUNT;
        SYNC:    if (lose) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    pos_d  = pos_q;
    miss_d = miss_q;
    emit_d = emit_q;
    if (i_valid) begin
      if (state_q == HUNT) begin
        pos_d = hit ? POS_AFTER : '0;
      end else if (state_d == HUNT) begin
        pos_d = '0;
      end else begin
        pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      end

      if (state_d == HUNT) begin
        miss_d = '0;
      end else if (at_chk && hit) begin
        miss_d = '0;
      end else if (at_chk && (state_q == SYNC)) begin
        miss_d = (miss_q >= MISS_SAT) ? miss_q : miss_q + 1'b1;
      end

      emit_d = lose ? 1'b0 : (emit_q | emit_set);
    end
  end

  always_comb begin
    data_d   = i_data;
    valid_d  = i_valid && (emit_q || emit_set);
    sof_d    = valid_d && (pos_q == '0);
    resync_d = lose;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pos_q    <= '0;
      miss_q   <= '0;
      emit_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      miss_q   <= miss_d;
      emit_q   <= emit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      resync_q <= resync_d;
    end
  end

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_sof    = sof_q;
  assign o_resync = resync_q;
  assign o_locked = (state_q == SYNC);

endmodule
